// File: rtl/serial_adder.sv
// Bit-serial adder: drives a single full-adder cell one bit per clock, LSB first,
// and publishes {cout,sum} = a + b + cin once all WIDTH bits are done.

module fullAdder2 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sa_reg, sa_next;
   logic [WIDTH-1:0] sb_reg, sb_next;
   logic [WIDTH-1:0] ps_reg, ps_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             carry_reg, carry_next;
   logic             cout_reg, cout_next;

   logic             fa_s, fa_cout;
   logic [WIDTH-1:0] ps_shift;

   fullAdder2 u_cell (
      .a    (sa_reg[0]),
      .b    (sb_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at ps[0].
   assign ps_shift[WIDTH-1] = fa_s;
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_ps_shift
         assign ps_shift[gi] = ps_reg[gi+1];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      sa_next    = sa_reg;
      sb_next    = sb_reg;
      ps_next    = ps_reg;
      count_next = count_reg;
      carry_next = carry_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               sa_next    = a;
               sb_next    = b;
               carry_next = cin;
               count_next = '0;
               ps_next    = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            carry_next = fa_cout;
            ps_next    = ps_shift;
            sa_next    = sa_reg >> 1;
            sb_next    = sb_reg >> 1;
            count_next = count_reg + ONE;
            if (count_reg == LAST) begin
               sum_next   = ps_shift;
               cout_next  = fa_cout;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         ps_reg    <= '0;
         count_reg <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         sa_reg    <= sa_next;
         sb_reg    <= sb_next;
         ps_reg    <= ps_next;
         count_reg <= count_next;
         carry_reg <= carry_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances, handshake timing,
// start masking, async reset abort, back-to-back throughput and a random sweep.

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout;
   logic [7:0] sum;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge after done drops.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec);
      int         busy_cycles;
      int         guard;
      logic       mid_change;
      logic [7:0] held;
      held = sum;
      mid_change = 1'b0;
      start = 1'b1; a = av; b = bv; cin = cv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = ~cv;
      busy_cycles = 0;
      guard = 0;
      while (!done && guard < 40) begin
         if (busy) busy_cycles++;
         if (sum !== held) mid_change = 1'b1;
         @(negedge clk);
         guard++;
      end
      check({tag, " done"}, done, 1);
      check({tag, " busy_cycles"}, busy_cycles, 8);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " sum"}, sum, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " sum_hidden"}, mid_change, 0);
      @(negedge clk);
      check({tag, " done_drop"}, done, 0);
      check({tag, " idle"}, busy, 0);
      $display("[TB] %s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d", tag, av, bv, cv, sum, cout);
   endtask

   initial begin
      int         pulse_at[4];
      int         npulse;
      int         unstable;
      logic       done_seen;
      logic [7:0] last_sum;
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] rexp;
      int         guard;

      // Reset state
      @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst sum", sum, 0);
      check("rst cout", cout, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors (hand-computed)
      run_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      run_op("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("vff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
      run_op("vzero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      run_op("vffffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_op("v8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

      // start during RUN and during DONE must be ignored
      start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("ign done", done, 1);
      check("ign sum", sum, 8'h96);
      check("ign cout", cout, 0);
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("ign not_queued", busy, 0);
      @(negedge clk);
      check("ign still_idle", busy, 0);
      check("ign sum_hold", sum, 8'h96);
      $display("[TB] ignore: sum=0x%02h after masked starts", sum);
      run_op("after_ign", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
      run_op("prior96", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

      // Asynchronous reset in the 4th RUN cycle
      start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("arst pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst busy", busy, 0);
      check("arst done", done, 0);
      check("arst sum", sum, 0);
      check("arst cout", cout, 0);
      done_seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         done_seen |= done;
      end
      check("arst no_done", done_seen, 0);
      rst_n = 1'b1;
      $display("[TB] async reset: outputs cleared mid-run");
      run_op("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

      // start held high for 30 cycles
      npulse = 0;
      unstable = 0;
      last_sum = sum;
      start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
      for (int n = 0; n < 32; n++) begin
         @(negedge clk);
         if (n == 29) start = 1'b0;
         if (done) begin
            if (npulse < 4) pulse_at[npulse] = n;
            npulse++;
            check("hold sum", sum, 8'h96);
         end else if (sum !== last_sum) begin
            unstable++;
         end
         last_sum = sum;
      end
      check("hold pulses", npulse, 3);
      if (npulse >= 3) begin
         check("hold gap1", pulse_at[1] - pulse_at[0], 10);
         check("hold gap2", pulse_at[2] - pulse_at[1], 10);
      end
      check("hold stable", unstable, 0);
      $display("[TB] held start: %0d done pulses", npulse);

      // WIDTH=1 instance
      for (int k = 0; k < 2; k++) begin
         start1 = 1'b1;
         a1 = 1'b1;
         b1 = (k == 0) ? 1'b1 : 1'b0;
         cin1 = (k == 0) ? 1'b1 : 1'b0;
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         check("w1 busy", busy1, 1);
         check("w1 early_done", done1, 0);
         @(negedge clk);
         check("w1 busy_drop", busy1, 0);
         check("w1 done", done1, 1);
         check("w1 sum", sum1, 1);
         check("w1 cout", cout1, (k == 0) ? 1 : 0);
         @(negedge clk);
         check("w1 done_drop", done1, 0);
         $display("[TB] w1 vec%0d: sum=%0d cout=%0d", k, sum1, cout1);
      end

      // Random sweep against a + b + cin
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         run_op($sformatf("rnd%0d", i), ra, rb, rc, rexp[7:0], rexp[8]);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
